dram_latency_responder: RTL and testbench

// - Synthesizable DRAM-side responder sitting directly downstream of Top's dramra/dramrd/dramw ports.
// - Replaces the software DRAM model for FPGA/emulation runs and closed-loop benches.
// - Accepts read addresses and returns the data after a fixed modelled latency, with output backpressure.
// - Accepts writes into a local word array.

---
 rtl/TauCfg.sv | 10 +
 rtl/dram_resp_fifo.sv | 81 ++++++++
 rtl/dram_latency_responder.sv | 122 ++++++++++++
 tb/tb_dram_latency_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/TauCfg.sv
// Shared DRAM bus configuration: default widths and word/address types.
package TauCfg;

  localparam int unsigned DRAM_AW = 16;
  localparam int unsigned DRAM_DW = 64;

  typedef logic [DRAM_DW-1:0] DramWord_t;
  typedef logic [DRAM_AW-1:0] DramAddr_t;

endpackage

// File: rtl/dram_resp_fifo.sv
// Synchronous response FIFO with a registered head-of-queue output word.
module dram_resp_fifo #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic [DW-1:0] o_data
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] store_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] data_q, data_d;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_data  = data_q;

  // Next pointers/occupancy; the output register tracks whichever entry will be the head.
  always_comb begin
    pop_ok   = i_pop && !o_empty;
    push_ok  = i_push && (!o_full || pop_ok);
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
    data_d = data_q;
    if (pop_ok) begin
      // Head moves on: next stored entry, or the word arriving this edge if the queue drains.
      if (count_q > CW'(1)) begin
        data_d = store_q[ptr_inc(rd_ptr_q)];
      end else if (push_ok) begin
        data_d = i_data;
      end
    end else if (push_ok && o_empty) begin
      data_d = i_data;
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
    end
  end

  // Entry storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      store_q[wr_ptr_q] <= i_data;
    end
  end

endmodule

// File: rtl/dram_latency_responder.sv
// DRAM-side responder: local word array, fixed-latency read pipeline, output FIFO.
module dram_latency_responder
  import TauCfg::*;
#(
  parameter int unsigned AW    = DRAM_AW,
  parameter int unsigned MAW   = 10,
  parameter int unsigned DW    = DRAM_DW,
  parameter int unsigned LAT   = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ra_rdy,
  output logic          o_ra_ack,
  input  logic [AW-1:0] i_ra_addr,
  output logic          o_rd_rdy,
  input  logic          i_rd_ack,
  output logic [DW-1:0] o_rd_data,
  input  logic          i_w_rdy,
  output logic          o_w_ack,
  input  logic [AW-1:0] i_w_addr,
  input  logic [DW-1:0] i_w_data
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0]  mem_q [2**MAW];
  logic [MAW-1:0] ra_idx, w_idx;
  logic [DW-1:0]  rd_word;
  logic           ra_fire, rd_fire, w_fire;
  logic [CW-1:0]  inflight_q, inflight_d;
  logic           fifo_push, fifo_full, fifo_empty;
  logic [DW-1:0]  fifo_push_data;

  // Upper address bits simply alias onto the implemented depth.
  assign ra_idx  = MAW'(i_ra_addr);
  assign w_idx   = MAW'(i_w_addr);
  assign rd_word = mem_q[ra_idx];

  // fifo_full implies inflight == DEPTH; kept as a cheap guard on the push side.
  assign o_ra_ack = !i_rst && (inflight_q < CW'(DEPTH)) && !fifo_full;
  assign o_w_ack  = !i_rst;
  assign o_rd_rdy = !fifo_empty;

  assign ra_fire = i_ra_rdy && o_ra_ack;
  assign rd_fire = o_rd_rdy && i_rd_ack;
  assign w_fire  = i_w_rdy && o_w_ack;

  // Word array; the read above samples the pre-write value on a same-edge collision.
  always_ff @(posedge i_clk) begin
    if (w_fire) begin
      mem_q[w_idx] <= i_w_data;
    end
  end

  // Outstanding reads across delay line and FIFO.
  always_comb begin
    inflight_d = inflight_q;
    if (ra_fire && !rd_fire) begin
      inflight_d = inflight_q + CW'(1);
    end else if (rd_fire && !ra_fire) begin
      inflight_d = inflight_q - CW'(1);
    end
  end

  // Inflight counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  generate
    if (LAT == 1) begin : g_nodelay
      assign fifo_push      = ra_fire;
      assign fifo_push_data = rd_word;
    end else begin : g_delay
      logic [LAT-2:0] vld_q;
      logic [DW-1:0]  dat_q [LAT-1];

      // Valid bits of the delay line; cleared so reset drops in-flight reads.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= ra_fire;
          for (int unsigned i = 1; i < LAT - 1; i++) begin
            vld_q[i] <= vld_q[i-1];
          end
        end
      end

      // Data side of the delay line, qualified by vld_q.
      always_ff @(posedge i_clk) begin
        dat_q[0] <= rd_word;
        for (int unsigned i = 1; i < LAT - 1; i++) begin
          dat_q[i] <= dat_q[i-1];
        end
      end

      assign fifo_push      = vld_q[LAT-2];
      assign fifo_push_data = dat_q[LAT-2];
    end
  endgenerate

  dram_resp_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_data  (fifo_push_data),
    .i_pop   (rd_fire),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_data  (o_rd_data)
  );

endmodule

// File: tb/tb_dram_latency_responder.sv
// Directed bench for dram_latency_responder (LAT=4, DEPTH=8, MAW=10).
module tb_dram_latency_responder;
  import TauCfg::*;

  localparam int unsigned MAW = 10;
  localparam int LAT = 4;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      ra_rdy = 1'b0;
  logic      ra_ack;
  DramAddr_t ra_addr = '0;
  logic      rd_rdy;
  logic      rd_ack = 1'b0;
  DramWord_t rd_data;
  logic      w_rdy = 1'b0;
  logic      w_ack;
  DramAddr_t w_addr = '0;
  DramWord_t w_data = '0;

  int n_vec = 0;
  int n_err = 0;

  DramWord_t model [2**MAW];
  int        acc_cyc [$];
  int        rsp_cyc [$];
  DramWord_t rsp_dat [$];

  always #5 clk = ~clk;

  dram_latency_responder #(
    .AW    (16),
    .MAW   (10),
    .DW    (64),
    .LAT   (4),
    .DEPTH (8)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_ra_rdy  (ra_rdy),
    .o_ra_ack  (ra_ack),
    .i_ra_addr (ra_addr),
    .o_rd_rdy  (rd_rdy),
    .i_rd_ack  (rd_ack),
    .o_rd_data (rd_data),
    .i_w_rdy   (w_rdy),
    .o_w_ack   (w_ack),
    .i_w_addr  (w_addr),
    .i_w_data  (w_data)
  );

  function automatic DramWord_t pat(input int i);
    return {16'hC0DE, 16'(i), 32'(i * 40503 + 1)};
  endfunction

  // Single write; called at a negedge, returns at the next negedge.
  task automatic write_word(input DramAddr_t a, input DramWord_t d);
    w_rdy = 1'b1; w_addr = a; w_data = d;
    #1;
    n_vec++;
    if (w_ack !== 1'b1) begin
      n_err++; $display("FAIL w_ack addr=%h: got %b want 1", a, w_ack);
    end
    @(negedge clk);
    w_rdy = 1'b0;
    model[a[MAW-1:0]] = d;
  endtask

  // Read engine; cycle index c is the posedge following the c-th negedge of the run.
  task automatic run_reads(input int n, input DramAddr_t base, input int stride,
                           input int ack_off, input int budget,
                           input int wcyc, input DramAddr_t waddr, input DramWord_t wdata);
    int issued = 0;
    int cyc = 0;
    acc_cyc.delete(); rsp_cyc.delete(); rsp_dat.delete();
    while ((issued < n || rsp_dat.size() < n) && cyc < budget) begin
      ra_rdy  = (issued < n);
      ra_addr = base + DramAddr_t'(issued * stride);
      rd_ack  = (cyc >= ack_off);
      w_rdy   = (cyc == wcyc);
      w_addr  = waddr;
      w_data  = wdata;
      #1;
      if (ra_rdy && ra_ack) begin
        acc_cyc.push_back(cyc);
        issued++;
      end
      if (rd_rdy && rd_ack) begin
        rsp_cyc.push_back(cyc);
        rsp_dat.push_back(rd_data);
      end
      @(negedge clk);
      cyc++;
    end
    ra_rdy = 1'b0; rd_ack = 1'b0; w_rdy = 1'b0;
    n_vec++;
    if (rsp_dat.size() != n) begin
      n_err++; $display("FAIL read_budget: got %0d responses want %0d", rsp_dat.size(), n);
    end
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    rd_ack = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      #1;
      n_vec++;
      if (rd_rdy !== 1'b0) begin
        n_err++; $display("FAIL %s idle cycle %0d: rd_rdy got %b want 0", tag, i, rd_rdy);
      end
      @(negedge clk);
    end
    rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (ra_ack !== 1'b0) begin n_err++; $display("FAIL reset ra_ack: got %b want 0", ra_ack); end
    n_vec++; if (rd_rdy !== 1'b0) begin n_err++; $display("FAIL reset rd_rdy: got %b want 0", rd_rdy); end
    n_vec++; if (rd_data !== 64'h0) begin n_err++; $display("FAIL reset rd_data: got %h want 0", rd_data); end
    n_vec++; if (w_ack !== 1'b0) begin n_err++; $display("FAIL reset w_ack: got %b want 0", w_ack); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (ra_ack !== 1'b1) begin n_err++; $display("FAIL post-reset ra_ack: got %b want 1", ra_ack); end
    n_vec++; if (w_ack !== 1'b1) begin n_err++; $display("FAIL post-reset w_ack: got %b want 1", w_ack); end
    @(negedge clk);
  endtask

  task automatic test_single_read();
    write_word(16'd5, 64'hA5);
    run_reads(1, 16'd5, 0, 0, 20, -1, '0, '0);
    if (rsp_dat.size() == 1) begin
      n_vec++; if (acc_cyc[0] != 0) begin n_err++; $display("FAIL t1 accept cycle: got %0d want 0", acc_cyc[0]); end
      n_vec++; if (rsp_cyc[0] != LAT) begin n_err++; $display("FAIL t1 latency: got %0d want %0d", rsp_cyc[0], LAT); end
      n_vec++; if (rsp_dat[0] !== 64'hA5) begin n_err++; $display("FAIL t1 data: got %h want a5", rsp_dat[0]); end
    end
    expect_idle("t1_one_beat", 4);
  endtask

  task automatic test_preload();
    for (int i = 0; i < 100; i++) write_word(DramAddr_t'(i), pat(i));
  endtask

  task automatic test_backpressure();
    int early = 0;
    run_reads(10, 16'd0, 1, 20, 80, -1, '0, '0);
    foreach (acc_cyc[j]) if (acc_cyc[j] < 20) early++;
    n_vec++;
    if (early != 8) begin n_err++; $display("FAIL t2 accepted while stalled: got %0d want 8", early); end
    if (acc_cyc.size() == 10) begin
      for (int j = 0; j < 8; j++) begin
        n_vec++; if (acc_cyc[j] != j) begin n_err++; $display("FAIL t2 accept[%0d]: got cycle %0d want %0d", j, acc_cyc[j], j); end
      end
      n_vec++; if (acc_cyc[8] != 21) begin n_err++; $display("FAIL t2 accept[8]: got cycle %0d want 21", acc_cyc[8]); end
      n_vec++; if (acc_cyc[9] != 22) begin n_err++; $display("FAIL t2 accept[9]: got cycle %0d want 22", acc_cyc[9]); end
    end
    foreach (rsp_dat[j]) begin
      n_vec++; if (rsp_dat[j] !== pat(j)) begin n_err++; $display("FAIL t2 data[%0d]: got %h want %h", j, rsp_dat[j], pat(j)); end
      n_vec++; if (rsp_cyc[j] != 20 + j) begin n_err++; $display("FAIL t2 resp cycle[%0d]: got %0d want %0d", j, rsp_cyc[j], 20 + j); end
    end
  endtask

  task automatic test_streaming();
    run_reads(100, 16'd0, 1, 0, 200, -1, '0, '0);
    foreach (acc_cyc[j]) begin
      n_vec++; if (acc_cyc[j] != j) begin n_err++; $display("FAIL t3 accept[%0d]: got cycle %0d want %0d", j, acc_cyc[j], j); end
    end
    foreach (rsp_dat[j]) begin
      n_vec++; if (rsp_cyc[j] != j + LAT) begin n_err++; $display("FAIL t3 resp cycle[%0d]: got %0d want %0d", j, rsp_cyc[j], j + LAT); end
      n_vec++; if (rsp_dat[j] !== pat(j)) begin n_err++; $display("FAIL t3 data[%0d]: got %h want %h", j, rsp_dat[j], pat(j)); end
    end
  endtask

  task automatic test_hazard();
    write_word(16'd3, 64'h22);
    run_reads(2, 16'd3, 0, 0, 30, 0, 16'd3, 64'h11);
    model[3] = 64'h11;
    if (rsp_dat.size() == 2) begin
      n_vec++; if (acc_cyc[1] != 1) begin n_err++; $display("FAIL t4 second accept: got cycle %0d want 1", acc_cyc[1]); end
      n_vec++; if (rsp_dat[0] !== 64'h22) begin n_err++; $display("FAIL t4 same-edge read: got %h want 22", rsp_dat[0]); end
      n_vec++; if (rsp_dat[1] !== 64'h11) begin n_err++; $display("FAIL t4 next-edge read: got %h want 11", rsp_dat[1]); end
    end
  endtask

  task automatic test_wrap();
    write_word(16'h0403, 64'h77);
    run_reads(1, 16'h0003, 0, 0, 20, -1, '0, '0);
    if (rsp_dat.size() == 1) begin
      n_vec++; if (rsp_dat[0] !== 64'h77) begin n_err++; $display("FAIL t5 wrap read 0003: got %h want 77", rsp_dat[0]); end
    end
    run_reads(1, 16'hFC03, 0, 0, 20, -1, '0, '0);
    if (rsp_dat.size() == 1) begin
      n_vec++; if (rsp_dat[0] !== 64'h77) begin n_err++; $display("FAIL t5 wrap read fc03: got %h want 77", rsp_dat[0]); end
    end
  endtask

  task automatic test_reset_midflight();
    rd_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ra_rdy = 1'b1; ra_addr = DramAddr_t'(10 + i);
      #1;
      n_vec++; if (ra_ack !== 1'b1) begin n_err++; $display("FAIL t6 accept %0d: ra_ack got %b want 1", i, ra_ack); end
      @(negedge clk);
    end
    ra_rdy = 1'b0;
    @(negedge clk);
    #1;
    n_vec++; if (rd_rdy !== 1'b1) begin n_err++; $display("FAIL t6 queued before reset: rd_rdy got %b want 1", rd_rdy); end
    #1 rst = 1'b1;
    #1;
    n_vec++; if (rd_rdy !== 1'b0) begin n_err++; $display("FAIL t6 async rd_rdy: got %b want 0", rd_rdy); end
    n_vec++; if (rd_data !== 64'h0) begin n_err++; $display("FAIL t6 async rd_data: got %h want 0", rd_data); end
    n_vec++; if (ra_ack !== 1'b0) begin n_err++; $display("FAIL t6 async ra_ack: got %b want 0", ra_ack); end
    n_vec++; if (w_ack !== 1'b0) begin n_err++; $display("FAIL t6 async w_ack: got %b want 0", w_ack); end
    @(negedge clk);
    rst = 1'b0;
    run_reads(1, 16'd5, 0, 0, 20, -1, '0, '0);
    if (rsp_dat.size() == 1) begin
      n_vec++; if (acc_cyc[0] != 0) begin n_err++; $display("FAIL t6 first accept: got cycle %0d want 0", acc_cyc[0]); end
      n_vec++; if (rsp_cyc[0] != LAT) begin n_err++; $display("FAIL t6 latency: got %0d want %0d", rsp_cyc[0], LAT); end
      n_vec++; if (rsp_dat[0] !== model[5]) begin n_err++; $display("FAIL t6 data: got %h want %h", rsp_dat[0], model[5]); end
    end
    expect_idle("t6_no_stale", 8);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_preload();
    test_backpressure();
    test_streaming();
    test_hazard();
    test_wrap();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
